// File: rtl/result_drain_unit.sv
// Result drain unit: captures a result chain, shifts it into a local buffer and
// serialises the buffered words onto a valid/ready stream, one harvest per Start.
module result_drain_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHAIN_DEPTH = 4
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic [4*DATA_WIDTH-1:0]   ResultIn_0,
  input  logic [4*DATA_WIDTH-1:0]   ResultIn_1,
  input  logic [4*DATA_WIDTH-1:0]   ResultIn_2,
  input  logic [4*DATA_WIDTH-1:0]   ResultIn_3,
  output logic                      ResultCapture,
  output logic [4*DATA_WIDTH-1:0]   Out_data,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic                      Out_last,
  output logic                      Busy,
  output logic                      Done,
  output logic [1:0]                state_dbg
);

  localparam int RW     = 4 * DATA_WIDTH;
  localparam int SW     = (CHAIN_DEPTH > 1) ? $clog2(CHAIN_DEPTH) : 1;
  localparam int WW     = SW + 2;
  localparam int NWORDS = 4 * CHAIN_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   shift_cnt;
  logic [WW-1:0]   word_cnt;
  logic            done_q;
  logic            shift_last;
  logic            word_last;
  logic            word_xfer;
  logic            in_drain;
  logic [SW-1:0]   rd_entry;
  logic [1:0]      rd_lane;
  logic [RW-1:0]   buf_mem [CHAIN_DEPTH][4];

  // Handshake: Out_valid is high for the whole DRAIN state; a word moves on a
  // cycle where Out_valid and Out_ready are both high, and Out_data/Out_last
  // hold their value until that happens.
  assign in_drain   = (state == DRAIN);
  assign word_xfer  = in_drain && Out_ready;
  assign shift_last = (shift_cnt == SW'(CHAIN_DEPTH - 1));
  assign word_last  = (word_cnt == WW'(NWORDS - 1));
  assign rd_entry   = word_cnt[WW-1:2];
  assign rd_lane    = word_cnt[1:0];
  assign state_dbg  = state;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SHIFT;
      SHIFT:   if (shift_last) state_nxt = DRAIN;
      DRAIN:   if (word_xfer && word_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ResultCapture = (state == CAPTURE);
    Busy          = (state != IDLE);
    Out_valid     = in_drain;
    Out_data      = '0;
    Out_last      = 1'b0;
    if (in_drain) begin
      Out_data = buf_mem[rd_entry][rd_lane];
      Out_last = word_last;
    end
    Done = done_q;
  end

  // Counters restart from zero outside their own state, so an aborted
  // harvest never leaves a stale index behind.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      shift_cnt <= '0;
      word_cnt  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= word_xfer && word_last;
      if (state == SHIFT) begin
        shift_cnt <= shift_last ? '0 : shift_cnt + SW'(1);
      end else begin
        shift_cnt <= '0;
      end
      if (in_drain) begin
        if (word_xfer) begin
          word_cnt <= word_last ? '0 : word_cnt + WW'(1);
        end
      end else begin
        word_cnt <= '0;
      end
    end
  end

  // Buffer is not reset: every entry is rewritten during SHIFT before DRAIN reads it.
  always_ff @(posedge Clk) begin
    if (state == SHIFT) begin
      buf_mem[shift_cnt][0] <= ResultIn_0;
      buf_mem[shift_cnt][1] <= ResultIn_1;
      buf_mem[shift_cnt][2] <= ResultIn_2;
      buf_mem[shift_cnt][3] <= ResultIn_3;
    end
  end

endmodule

// File: tb/tb_result_drain_unit.sv
// Bench for result_drain_unit: a result-chain model feeds the tail lanes, a
// scoreboard queue holds the expected word stream, and a table drives harvests.
module tb_result_drain_unit;

  localparam int DW     = 8;
  localparam int D      = 4;
  localparam int RW     = 4 * DW;
  localparam int NW     = 4 * D;
  localparam int BUDGET = 600;

  logic          Clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [RW-1:0] ResultIn_0, ResultIn_1, ResultIn_2, ResultIn_3;
  logic          ResultCapture;
  logic [RW-1:0] Out_data;
  logic          Out_valid;
  logic          Out_ready;
  logic          Out_last;
  logic          Busy;
  logic          Done;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] local_res [D][4];
  logic [RW-1:0] snap      [D][4];
  int            chain_off = D;
  bit            rnd_rdy   [1024];

  typedef struct {
    logic [RW-1:0] base;
    int            ready_mode;  // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int            stray_start;
    bit            chain_next;
    int            abort_at;
    bit            rand_data;
    int            exp_done;    // -1: take it from the reference model
  } vec_t;

  vec_t tv [11];

  result_drain_unit #(.DATA_WIDTH(DW), .CHAIN_DEPTH(D)) dut (
    .Clk(Clk), .rst(rst), .Start(Start),
    .ResultIn_0(ResultIn_0), .ResultIn_1(ResultIn_1),
    .ResultIn_2(ResultIn_2), .ResultIn_3(ResultIn_3),
    .ResultCapture(ResultCapture), .Out_data(Out_data), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Out_last(Out_last), .Busy(Busy), .Done(Done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // Result chain: capture loads every cell, otherwise the chain moves one cell
  // towards the tail per cycle and zeros enter at the head.
  always @(posedge Clk) begin
    if (ResultCapture) begin
      snap      <= local_res;
      chain_off <= 0;
    end else if (chain_off < D) begin
      chain_off <= chain_off + 1;
    end
  end
  assign ResultIn_0 = (chain_off < D) ? snap[chain_off][0] : '0;
  assign ResultIn_1 = (chain_off < D) ? snap[chain_off][1] : '0;
  assign ResultIn_2 = (chain_off < D) ? snap[chain_off][2] : '0;
  assign ResultIn_3 = (chain_off < D) ? snap[chain_off][3] : '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      default: return rnd_rdy[c % 1024];
    endcase
  endfunction

  // Cycle (counted from the Start cycle) on which Done is expected: DRAIN opens
  // after one capture cycle and D shift cycles, then NW ready cycles are needed.
  function automatic int model_done(input int mode);
    int c = 2 + D;
    int n = 0;
    while (n < NW && c < BUDGET) begin
      if (rdy(mode, c)) n++;
      c++;
    end
    return c;
  endfunction

  // scoreboard / stream monitor
  int            recv_idx   = 0;
  bit            stall_prev = 1'b0;
  logic [RW-1:0] held_data;
  logic          held_last;

  always @(negedge Clk) begin
    if (rst) begin
      recv_idx   = 0;
      stall_prev = 1'b0;
    end
    if (!Out_valid) begin
      check("idle_data_zero", Out_data, '0);
      check("idle_last_zero", Out_last, 1'b0);
    end else begin
      if (stall_prev) begin
        check("stall_data_stable", Out_data, held_data);
        check("stall_last_stable", Out_last, held_last);
      end
      if (Out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none at %0t", Out_data, $time);
        end else begin
          logic [RW-1:0] e;
          e = exp_q.pop_front();
          check("word", Out_data, e);
          check("last_flag", Out_last, recv_idx == NW - 1);
        end
        recv_idx = (recv_idx == NW - 1) ? 0 : recv_idx + 1;
      end
    end
    stall_prev = Out_valid && !Out_ready;
    held_data  = Out_data;
    held_last  = Out_last;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rc"},    ResultCapture, 1'b0);
    check({tag, "_valid"}, Out_valid, 1'b0);
    check({tag, "_last"},  Out_last, 1'b0);
    check({tag, "_data"},  Out_data, '0);
    check({tag, "_busy"},  Busy, 1'b0);
    check({tag, "_done"},  Done, 1'b0);
  endtask

  // driver: entered and left at posedge+1
  task automatic run_harvest(input vec_t v);
    int cyc      = 0;
    bit got_done = 1'b0;
    int exp_done;
    for (int i = 0; i < 1024; i++) rnd_rdy[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < D; k++) begin
      for (int l = 0; l < 4; l++) begin
        local_res[k][l] = v.rand_data ? RW'($urandom) : v.base + RW'(k + l);
        exp_q.push_back(local_res[k][l]);
      end
    end
    exp_done  = (v.exp_done >= 0) ? v.exp_done : model_done(v.ready_mode);
    Start     = 1'b1;
    Out_ready = rdy(v.ready_mode, 0);
    while (!got_done && cyc < BUDGET) begin
      @(posedge Clk);
      #1;
      cyc++;
      Start     = (cyc == v.stray_start);
      Out_ready = rdy(v.ready_mode, cyc);
      if (cyc == v.abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(posedge Clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
          @(posedge Clk);
          #1;
          check("no_done_after_abort", Done, 1'b0);
          check("no_valid_after_abort", Out_valid, 1'b0);
        end
        return;
      end
      check("result_capture", ResultCapture, cyc == 1);
      if (Done) begin
        got_done = 1'b1;
        check("done_latency", cyc, exp_done);
        check("busy_on_done", Busy, 1'b0);
        check("queue_empty_on_done", exp_q.size(), 0);
      end else begin
        check("busy_in_harvest", Busy, 1'b1);
      end
    end
    if (!got_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=%0d cycles", exp_done);
      exp_q.delete();
      rst = 1'b1;
      @(posedge Clk);
      #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    //        base       mode stray chain abort rand done
    tv[0]  = '{32'h0A0,  0,   -1,   0,    -1,   0,   22};
    tv[1]  = '{32'h0,    1,   -1,   0,    -1,   1,   37};
    tv[2]  = '{32'h100,  0,    3,   0,    -1,   0,   22};
    tv[3]  = '{32'h200,  0,   15,   0,    -1,   0,   22};
    tv[4]  = '{32'h010,  0,   -1,   0,     8,   0,   22};
    tv[5]  = '{32'h300,  0,   -1,   0,    -1,   0,   22};
    tv[6]  = '{32'h400,  0,   -1,   1,    -1,   0,   22};
    tv[7]  = '{32'h500,  0,   -1,   0,    -1,   0,   22};
    tv[8]  = '{32'h0,    2,   -1,   0,    -1,   1,   -1};
    tv[9]  = '{32'h0,    2,    5,   1,    -1,   1,   -1};
    tv[10] = '{32'h0,    1,   -1,   0,    -1,   1,   37};

    rst       = 1'b1;
    Start     = 1'b0;
    Out_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      for (int l = 0; l < 4; l++) local_res[k][l] = '0;
    end
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge Clk);
    #1;
    check_reset_outputs("post_reset");

    for (int i = 0; i < 11; i++) begin
      run_harvest(tv[i]);
      if (!tv[i].chain_next && tv[i].abort_at < 0) begin
        @(posedge Clk);
        #1;
        check("done_single_cycle", Done, 1'b0);
        check("idle_not_busy", Busy, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge Clk);
        #1;
      end
    end

    repeat (3) @(posedge Clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_drain_unit.md
RESULT_DRAIN_UNIT -- requirements
Module: result_drain_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, activation/weight width; each result word is 4*DATA_WIDTH bits.
REQ-002 SHALL have parameter CHAIN_DEPTH, default 4, number of cells in the result chain; legal range 1..16.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port Start, input, 1, one-cycle request to harvest the chain.
REQ-006 SHALL have ports ResultIn_0..ResultIn_3, input, 4*DATA_WIDTH each, four result lanes from the chain tail.
REQ-007 SHALL have port ResultCapture, output, 1, drives every cell's capture/shift select (1 = load local result, 0 = shift).
REQ-008 SHALL have port Out_data, output, 4*DATA_WIDTH, serialized result word.
REQ-009 SHALL have port Out_valid, output, 1, Out_data holds a valid word.
REQ-010 SHALL have port Out_ready, input, 1, downstream accepts the word.
REQ-011 SHALL have port Out_last, output, 1, asserted with the final word of a harvest.
REQ-012 SHALL have port Busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port Done, output, 1, one-cycle pulse on the cycle after the last word transfers.

Function
REQ-014 SHALL implement FSM states IDLE, CAPTURE, SHIFT, DRAIN.
REQ-015 IDLE -> CAPTURE when Start=1; Start SHALL be ignored in every other state.
REQ-016 CAPTURE SHALL last exactly one cycle with ResultCapture=1, then go to SHIFT; ResultCapture SHALL be 0 in all other states.
REQ-017 SHIFT SHALL last exactly CHAIN_DEPTH cycles; on each cycle, the four ResultIn lanes SHALL be stored as buffer entry k (k = 0..CHAIN_DEPTH-1), with entry 0 coming from the tail cell.
REQ-018 SHIFT SHALL NOT stall for Out_ready, since the chain shifts every cycle; the buffer SHALL hold CHAIN_DEPTH entries x 4 lanes.
REQ-019 SHIFT -> DRAIN after the CHAIN_DEPTH-th sample.
REQ-020 DRAIN SHALL emit 4*CHAIN_DEPTH words in order entry 0 lane 0, entry 0 lane 1, ... entry 0 lane 3, entry 1 lane 0, and so on.
REQ-021 Out_valid SHALL be high throughout DRAIN; a word transfers on a cycle where Out_valid=1 and Out_ready=1.
REQ-022 Out_data and Out_last SHALL stay stable while Out_valid=1 and Out_ready=0.
REQ-023 Out_last SHALL be 1 only with word index 4*CHAIN_DEPTH-1.
REQ-024 After the last transfer, the FSM SHALL go to IDLE, and Done SHALL be 1 for that next cycle only.
REQ-025 With Out_ready held high, one word SHALL transfer per cycle; total latency from Start to Done = 1 + 1 + CHAIN_DEPTH + 4*CHAIN_DEPTH cycles.
REQ-026 Start asserted on the Done cycle SHALL be accepted, since the FSM is in IDLE.
REQ-027 Word and entry counters SHALL be sized for 4*CHAIN_DEPTH and SHALL NOT wrap within one harvest.
REQ-028 Out_data SHALL be 0 whenever Out_valid=0.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, with ResultCapture=0, Out_valid=0, Out_last=0, Out_data=0, Busy=0, Done=0, and counters=0.
REQ-030 Reset mid-harvest SHALL discard all buffered words; no partial transfer or Done SHALL follow.
REQ-031 Buffer contents need not be cleared by reset, but SHALL never be emitted before being rewritten.

Verification
REQ-032 CHAIN_DEPTH=4, Out_ready=1, tail lanes sampled in SHIFT = 32'h0A0+k..32'h0A3+k -> 16 words 0A0,0A1,0A2,0A3,0A1,...,0A6 in order; Out_last on word 15; Done 22 cycles after Start.
REQ-033 Start pulse -> ResultCapture high for exactly one cycle (the cycle after Start); Start pulsed again while Busy -> no effect, ResultCapture not re-asserted.
REQ-034 Out_ready toggled 1,0,0,1 repeatedly during DRAIN -> no word lost or duplicated; Out_data is stable across stalls; all 16 words arrive in order.
REQ-035 rst asserted on the 3rd DRAIN word -> all outputs 0 in the same cycle; a new Start after release yields a full fresh 16-word harvest.
REQ-036 Start asserted on the Done cycle -> a second harvest begins with no idle gap; Out_last appears once per harvest.
